prog_rom: RTL

PROG_ROM -- requirements
Module: prog_rom

---
 rtl/prog_rom_pkg.sv | 15 +
 rtl/prog_rom_loader.sv | 29 ++
 rtl/prog_rom.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prog_rom_pkg.sv
// Shared types and sizes for the program ROM slice.
// The WAIT state exists only when PROG_ROM_WAIT_STATE_EN is defined.
package prog_rom_pkg;

  localparam int ROM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

`ifdef PROG_ROM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE, READ, LOAD, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;
`endif

endpackage

// File: rtl/prog_rom_loader.sv
// Write pointer for program loading, with sticky wrap detection.
// start and wr arrive already qualified by the top-level enable.
module prog_rom_loader
  import prog_rom_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr,
  output logic [ADDR_W-1:0] ptr,
  output logic              load_wrap
);

  // The wrap flag latches on the write that takes the pointer from the last slot back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      load_wrap <= 1'b0;
    end else if (start) begin
      ptr       <= '0;
      load_wrap <= 1'b0;
    end else if (wr) begin
      ptr <= ptr + 1'b1;
      if (ptr == ADDR_W'(ROM_DEPTH - 1))
        load_wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/prog_rom.sv
// Loadable 256x8 program ROM with a one-result-per-cycle read port.
// Define PROG_ROM_WAIT_STATE_EN to insert a WAIT state (2-cycle read latency).
module prog_rom
  import prog_rom_pkg::*;
(
  input  logic              clk_tb,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              rd_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              load_en,
  input  logic              load_strobe,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic              load_wrap
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] mem [ROM_DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] read_addr;
  logic              load_start;
  logic              load_wr;
  logic              read_fire;
  logic              valid_q;

`ifdef PROG_ROM_WAIT_STATE_EN
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst)
      addr_q <= '0;
    else if (enable && next_state == WAIT)
      addr_q <= addr_in;
  end
`endif

  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else if (enable)
      state <= next_state;
  end

  // read_fire marks every transition into READ; the read path captures data on it.
  always_comb begin
    next_state = state;
    load_start = 1'b0;
    load_wr    = 1'b0;
    read_fire  = 1'b0;
    read_addr  = addr_in;
    case (state)
      IDLE: begin
        if (load_en) begin
          next_state = LOAD;
          load_start = 1'b1;
        end else if (rd_req) begin
`ifdef PROG_ROM_WAIT_STATE_EN
          next_state = WAIT;
`else
          next_state = READ;
          read_fire  = 1'b1;
`endif
        end
      end
      READ: begin
        if (rd_req && !load_en) begin
`ifdef PROG_ROM_WAIT_STATE_EN
          next_state = WAIT;
`else
          next_state = READ;
          read_fire  = 1'b1;
`endif
        end else begin
          next_state = IDLE;
        end
      end
`ifdef PROG_ROM_WAIT_STATE_EN
      WAIT: begin
        next_state = READ;
        read_fire  = 1'b1;
        read_addr  = addr_q;
      end
`endif
      LOAD: begin
        if (!load_en)
          next_state = IDLE;
        else
          load_wr = load_strobe;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst)
      load_busy <= 1'b0;
    else if (enable)
      load_busy <= (next_state == LOAD);
  end

  // Data is fetched as the FSM enters READ, so data_out is stable for the whole valid cycle.
  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      valid_q  <= 1'b0;
    end else if (enable) begin
      valid_q <= read_fire;
      if (read_fire)
        data_out <= mem[read_addr];
    end
  end

  assign data_valid = valid_q & enable;

  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_DEPTH; i++)
        mem[i] <= '0;
    end else if (enable && load_wr) begin
      mem[ptr] <= load_data;
    end
  end

  prog_rom_loader u_loader (
    .clk       (clk_tb),
    .rst_n     (rst),
    .start     (enable & load_start),
    .wr        (enable & load_wr),
    .ptr       (ptr),
    .load_wrap (load_wrap)
  );

endmodule
